// File: rtl/sccb_slave_pkg.sv
// Shared types and constants for the SCCB responder: FSM states, default device ID, and the ACK level.
`timescale 1ns/1ps
package sccb_slave_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ID     = 3'd1,
        ST_ADDR_H = 3'd2,
        ST_ADDR_L = 3'd3,
        ST_WDATA  = 3'd4,
        ST_RDATA  = 3'd5,
        ST_RD_NA  = 3'd6,
        ST_IGNORE = 3'd7
    } state_t;

    localparam logic [7:0] DEF_DEV_ADDR  = 8'h78;
    localparam logic       SCCB_ACK      = 1'b0;
    localparam logic [3:0] BITS_PER_BYTE = 4'd8;

    // The R/W bit (bit 0) never takes part in the ID comparison.
    function automatic logic id_match(input logic [7:0] id, input logic [7:0] dev);
        return (id | 8'h01) == (dev | 8'h01);
    endfunction

endpackage

// File: rtl/sccb_slave_line_sync.sv
// Brings SIOC/SIOD into the i_clk domain and derives level plus rise/fall strobes for both lines.
`timescale 1ns/1ps
module sccb_slave_line_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sioc,
    input  logic i_siod,
    output logic o_sioc,
    output logic o_siod,
    output logic o_sioc_rise,
    output logic o_sioc_fall,
    output logic o_siod_rise,
    output logic o_siod_fall
);

    // Each stage carries {sioc, siod}; the last stage is the synchronized level.
    logic [SYNC_STAGES-1:0][1:0] sync_q, sync_d;
    logic [1:0]                  hist_q, hist_d;
    logic [1:0]                  level;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], i_sioc, i_siod};
        hist_d = sync_q[SYNC_STAGES-1];
    end

    // NOTE: an idle bus is high, so the chain resets to 1 and no edge appears at reset release.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            sync_q <= '1;
            hist_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
            hist_q <= hist_d;
        end
    end

    assign level       = sync_q[SYNC_STAGES-1];
    assign o_sioc      = level[1];
    assign o_siod      = level[0];
    assign o_sioc_rise = level[1] & ~hist_q[1];
    assign o_sioc_fall = ~level[1] & hist_q[1];
    assign o_siod_rise = level[0] & ~hist_q[0];
    assign o_siod_fall = ~level[0] & hist_q[0];

endmodule

// File: rtl/sccb_slave.sv
// SCCB responder: decodes 3-phase writes and 2-phase reads, drives ACK/read data on SIOD and
// presents a register-file write/read port with an auto-incrementing 16-bit address pointer.
`timescale 1ns/1ps
module sccb_slave
    import sccb_slave_pkg::*;
#(
    parameter logic [7:0] DEV_ADDR    = DEF_DEV_ADDR,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sioc,
    input  logic        i_siod_in,
    output logic        o_siod_oe,
    output logic        o_siod_out,
    output logic        o_wr_en,
    output logic [15:0] o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_rd_req,
    output logic [15:0] o_rd_addr,
    input  logic [7:0]  i_rd_data,
    output logic        o_busy
);

    logic sioc, siod, sioc_rise, sioc_fall, siod_rise, siod_fall;
    logic start_det, stop_det, rx_state;
    logic [7:0] byte_in;

    state_t      state_q,    state_d;
    logic [3:0]  bit_cnt_q,  bit_cnt_d;
    logic [7:0]  shift_q,    shift_d;
    logic [15:0] ptr_q,      ptr_d;
    logic        ack_q,      ack_d;
    logic        rd_pend_q,  rd_pend_d;
    logic [7:0]  rd_shift_q, rd_shift_d;
    logic        oe_q,       oe_d;
    logic        out_q,      out_d;
    logic        busy_q,     busy_d;
    logic        wr_en_q,    wr_en_d;
    logic [15:0] wr_addr_q,  wr_addr_d;
    logic [7:0]  wr_data_q,  wr_data_d;
    logic        rd_req_q,   rd_req_d;
    logic [15:0] rd_addr_q,  rd_addr_d;

    sccb_slave_line_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_line_sync (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_sioc      (i_sioc),
        .i_siod      (i_siod_in),
        .o_sioc      (sioc),
        .o_siod      (siod),
        .o_sioc_rise (sioc_rise),
        .o_sioc_fall (sioc_fall),
        .o_siod_rise (siod_rise),
        .o_siod_fall (siod_fall)
    );

    assign start_det = siod_fall & sioc;
    assign stop_det  = siod_rise & sioc;
    assign rx_state  = (state_q == ST_ID)     || (state_q == ST_ADDR_H) ||
                       (state_q == ST_ADDR_L) || (state_q == ST_WDATA);
    assign byte_in   = {shift_q[6:0], siod};

    // ack_q marks an ACK slot (ours or the master's); the fall that closes it starts the next byte.
    always_comb begin
        // NOTE: every _d starts from its _q (pulses from 0) so no path leaves a latch behind.
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        ack_d      = ack_q;
        rd_pend_d  = 1'b0;
        rd_shift_d = rd_shift_q;
        oe_d       = oe_q;
        out_d      = out_q;
        busy_d     = busy_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_req_d   = 1'b0;
        rd_addr_d  = rd_addr_q;

        if (rd_pend_q) begin
            rd_shift_d = i_rd_data;
        end

        if (start_det) begin
            state_d   = ST_ID;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
            oe_d      = 1'b0;
            out_d     = 1'b0;
        end else if (stop_det) begin
            state_d   = ST_IDLE;
            bit_cnt_d = 4'd0;
            ack_d     = 1'b0;
            oe_d      = 1'b0;
            out_d     = 1'b0;
            busy_d    = 1'b0;
        end else if (sioc_rise) begin
            if (rx_state && !ack_q && (bit_cnt_q < BITS_PER_BYTE)) begin
                shift_d   = byte_in;
                bit_cnt_d = bit_cnt_q + 4'd1;
                if ((state_q == ST_WDATA) && (bit_cnt_q == BITS_PER_BYTE - 4'd1)) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = byte_in;
                    ptr_d     = ptr_q + 16'd1;
                end
            end else if (state_q == ST_RD_NA) begin
                if (siod) begin
                    state_d = ST_IGNORE;
                end else begin
                    ptr_d     = ptr_q + 16'd1;
                    rd_req_d  = 1'b1;
                    rd_addr_d = ptr_q + 16'd1;
                    rd_pend_d = 1'b1;
                    ack_d     = 1'b1;
                    state_d   = ST_RDATA;
                end
            end
        end else if (sioc_fall) begin
            if (ack_q) begin
                ack_d     = 1'b0;
                bit_cnt_d = 4'd0;
                if (state_q == ST_RDATA) begin
                    oe_d       = 1'b1;
                    out_d      = rd_shift_q[7];
                    rd_shift_d = {rd_shift_q[6:0], 1'b0};
                    bit_cnt_d  = 4'd1;
                end else begin
                    oe_d  = 1'b0;
                    out_d = 1'b0;
                end
            end else if (rx_state && (bit_cnt_q == BITS_PER_BYTE)) begin
                ack_d = 1'b1;
                oe_d  = 1'b1;
                out_d = SCCB_ACK;
                case (state_q)
                    ST_ID: begin
                        if (!id_match(shift_q, DEV_ADDR)) begin
                            state_d = ST_IGNORE;
                            ack_d   = 1'b0;
                            oe_d    = 1'b0;
                            busy_d  = 1'b0;
                        end else begin
                            busy_d = 1'b1;
                            if (shift_q[0]) begin
                                rd_req_d  = 1'b1;
                                rd_addr_d = ptr_q;
                                rd_pend_d = 1'b1;
                                state_d   = ST_RDATA;
                            end else begin
                                state_d = ST_ADDR_H;
                            end
                        end
                    end
                    ST_ADDR_H: begin
                        ptr_d[15:8] = shift_q;
                        state_d     = ST_ADDR_L;
                    end
                    ST_ADDR_L: begin
                        ptr_d[7:0] = shift_q;
                        state_d    = ST_WDATA;
                    end
                    default: begin
                        state_d = state_q;
                    end
                endcase
            end else if (state_q == ST_RDATA) begin
                if (bit_cnt_q < BITS_PER_BYTE) begin
                    out_d      = rd_shift_q[7];
                    rd_shift_d = {rd_shift_q[6:0], 1'b0};
                    bit_cnt_d  = bit_cnt_q + 4'd1;
                end else begin
                    oe_d      = 1'b0;
                    out_d     = 1'b0;
                    bit_cnt_d = 4'd0;
                    state_d   = ST_RD_NA;
                end
            end
        end
    end

    // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= 4'd0;
            shift_q    <= 8'h00;
            ptr_q      <= 16'h0000;
            ack_q      <= 1'b0;
            rd_pend_q  <= 1'b0;
            rd_shift_q <= 8'h00;
            oe_q       <= 1'b0;
            out_q      <= 1'b0;
            busy_q     <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= 16'h0000;
            wr_data_q  <= 8'h00;
            rd_req_q   <= 1'b0;
            rd_addr_q  <= 16'h0000;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            ack_q      <= ack_d;
            rd_pend_q  <= rd_pend_d;
            rd_shift_q <= rd_shift_d;
            oe_q       <= oe_d;
            out_q      <= out_d;
            busy_q     <= busy_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_req_q   <= rd_req_d;
            rd_addr_q  <= rd_addr_d;
        end
    end

    assign o_siod_oe  = oe_q;
    assign o_siod_out = out_q;
    assign o_busy     = busy_q;
    assign o_wr_en    = wr_en_q;
    assign o_wr_addr  = wr_addr_q;
    assign o_wr_data  = wr_data_q;
    assign o_rd_req   = rd_req_q;
    assign o_rd_addr  = rd_addr_q;

endmodule

// File: tb/tb_sccb_slave.sv
// Bench for sccb_slave: bit-banged SCCB master on an open-drain bus, a register file behind the
// responder port, and a transaction-level model of pointer/write/read behaviour.
`timescale 1ns/1ps
module tb_sccb_slave;

    localparam int Q = 40;  // quarter SIOC period in ns; i_clk runs 16x SIOC

    logic        i_clk, i_rst, i_sioc, m_sda, i_siod_in;
    logic        o_siod_oe, o_siod_out, o_wr_en, o_rd_req, o_busy;
    logic [15:0] o_wr_addr, o_rd_addr;
    logic [7:0]  o_wr_data, i_rd_data;

    // Open-drain bus: the master releases with 1, the responder pulls low when driving a 0.
    assign i_siod_in = m_sda & (o_siod_oe ? o_siod_out : 1'b1);

    sccb_slave #(
        .DEV_ADDR    (8'h78),
        .SYNC_STAGES (2)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_sioc     (i_sioc),
        .i_siod_in  (i_siod_in),
        .o_siod_oe  (o_siod_oe),
        .o_siod_out (o_siod_out),
        .o_wr_en    (o_wr_en),
        .o_wr_addr  (o_wr_addr),
        .o_wr_data  (o_wr_data),
        .o_rd_req   (o_rd_req),
        .o_rd_addr  (o_rd_addr),
        .i_rd_data  (i_rd_data),
        .o_busy     (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [15:0] m_ptr;
    logic [7:0]  m_mem [int];
    logic [7:0]  rf    [int];
    logic [23:0] exp_wr_q [$];
    logic [15:0] exp_rd_q [$];
    logic [7:0]  tx_q [$];
    int          wr_seen = 0;
    logic [15:0] last_wr_addr, prev_wr_addr, last_rd_addr;
    logic [7:0]  last_wr_data, prev_wr_data, last_rd_byte;
    logic [23:0] cmp_wr;
    logic [15:0] cmp_rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] def_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hC3;
    endfunction

    function automatic logic [7:0] m_read(input logic [15:0] a);
        return m_mem.exists(int'(a)) ? m_mem[int'(a)] : def_byte(a);
    endfunction

    function automatic logic [7:0] rf_read(input logic [15:0] a);
        return rf.exists(int'(a)) ? rf[int'(a)] : def_byte(a);
    endfunction

    // Compare process and register file: runs on every falling i_clk edge.
    always @(negedge i_clk) begin
        if (!i_rst) begin
            check("siod_out_while_released", {31'd0, o_siod_out & ~o_siod_oe}, 32'd0);
            if (o_wr_en) begin
                rf[int'(o_wr_addr)] = o_wr_data;
                prev_wr_addr = last_wr_addr;
                prev_wr_data = last_wr_data;
                last_wr_addr = o_wr_addr;
                last_wr_data = o_wr_data;
                wr_seen++;
                check("wr_expected", {31'd0, exp_wr_q.size() > 0}, 32'd1);
                if (exp_wr_q.size() > 0) begin
                    cmp_wr = exp_wr_q.pop_front();
                    check("wr_addr", {16'd0, o_wr_addr}, {16'd0, cmp_wr[23:8]});
                    check("wr_data", {24'd0, o_wr_data}, {24'd0, cmp_wr[7:0]});
                end
            end
            if (o_rd_req) begin
                last_rd_addr = o_rd_addr;
                i_rd_data    = rf_read(o_rd_addr);
                check("rd_expected", {31'd0, exp_rd_q.size() > 0}, 32'd1);
                if (exp_rd_q.size() > 0) begin
                    cmp_rd = exp_rd_q.pop_front();
                    check("rd_addr", {16'd0, o_rd_addr}, {16'd0, cmp_rd});
                end
            end else begin
                i_rd_data = 8'($urandom);
            end
        end
    end

    task automatic xfer_bit(input logic b, output logic s);
        #Q m_sda = b;
        #Q i_sioc = 1'b1;
        #Q s = i_siod_in;
        #Q i_sioc = 1'b0;
    endtask

    task automatic bus_start();
        if (i_sioc == 1'b0) begin
            #Q m_sda = 1'b1;
            #Q i_sioc = 1'b1;
            #Q;
        end else begin
            #Q;
        end
        m_sda = 1'b0;
        #Q i_sioc = 1'b0;
    endtask

    task automatic bus_stop();
        #Q m_sda = 1'b0;
        #Q i_sioc = 1'b1;
        #Q m_sda = 1'b1;
        #(3*Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) xfer_bit(b[i], s);
        xfer_bit(1'b1, ack);
    endtask

    // Write transaction: ID, then tx_q bytes (2 address bytes then data), optional stop.
    task automatic write_txn(input logic [7:0] id, input bit do_stop);
        logic ack;
        logic match;
        match = (id == 8'h78);
        bus_start();
        send_byte(id, ack);
        check("id_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        check("busy_after_id", {31'd0, o_busy}, {31'd0, match});
        for (int i = 0; i < tx_q.size(); i++) begin
            if (match) begin
                if (i == 0) m_ptr[15:8] = tx_q[i];
                else if (i == 1) m_ptr[7:0] = tx_q[i];
                else begin
                    exp_wr_q.push_back({m_ptr, tx_q[i]});
                    m_mem[int'(m_ptr)] = tx_q[i];
                    m_ptr++;
                end
            end
            send_byte(tx_q[i], ack);
            check("byte_ack", {31'd0, ack}, match ? 32'd0 : 32'd1);
        end
        if (do_stop) begin
            bus_stop();
            check("busy_after_stop", {31'd0, o_busy}, 32'd0);
            check("wr_missing", exp_wr_q.size(), 32'd0);
        end
    endtask

    // Read transaction of n bytes from the current pointer; master NAs the last byte.
    task automatic read_txn(input int n);
        logic ack;
        logic s;
        logic [7:0] d;
        bus_start();
        exp_rd_q.push_back(m_ptr);
        send_byte(8'h79, ack);
        check("rd_id_ack", {31'd0, ack}, 32'd0);
        check("busy_rd", {31'd0, o_busy}, 32'd1);
        for (int i = 0; i < n; i++) begin
            for (int b = 7; b >= 0; b--) begin
                xfer_bit(1'b1, s);
                d[b] = s;
            end
            check("rd_data", {24'd0, d}, {24'd0, m_read(m_ptr)});
            last_rd_byte = d;
            if (i != n - 1) begin
                m_ptr++;
                exp_rd_q.push_back(m_ptr);
            end
            #Q m_sda = (i == n - 1);
            #Q i_sioc = 1'b1;
            #Q check("master_slot_oe", {31'd0, o_siod_oe}, 32'd0);
            #Q i_sioc = 1'b0;
        end
        bus_stop();
        check("rd_missing", exp_rd_q.size(), 32'd0);
        check("busy_after_rd", {31'd0, o_busy}, 32'd0);
    endtask

    initial begin
        #900us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int          base;
        int          k;
        logic        s;
        logic [7:0]  dev;
        logic [7:0]  id;
        logic [15:0] burst_addr;

        i_rst = 1'b1; i_sioc = 1'b1; m_sda = 1'b1; i_rd_data = 8'h00; m_ptr = 16'h0000;
        burst_addr = 16'h0000;
        repeat (4) @(posedge i_clk);
        #1;
        check("rst_oe", {31'd0, o_siod_oe}, 32'd0);
        check("rst_out", {31'd0, o_siod_out}, 32'd0);
        check("rst_wr_en", {31'd0, o_wr_en}, 32'd0);
        check("rst_rd_req", {31'd0, o_rd_req}, 32'd0);
        check("rst_busy", {31'd0, o_busy}, 32'd0);
        check("rst_wr_addr", {16'd0, o_wr_addr}, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);

        // 1: single write BEEF = AA
        base = wr_seen;
        tx_q = '{8'hBE, 8'hEF, 8'hAA};
        write_txn(8'h78, 1'b1);
        check("t1_wr_count", wr_seen - base, 32'd1);
        check("t1_wr_addr", {16'd0, last_wr_addr}, 32'h0000BEEF);
        check("t1_wr_data", {24'd0, last_wr_data}, 32'h000000AA);

        // 2: burst across the 16-bit wrap
        base = wr_seen;
        tx_q = '{8'hFF, 8'hFF, 8'h11, 8'h22};
        write_txn(8'h78, 1'b1);
        check("t2_wr_count", wr_seen - base, 32'd2);
        check("t2_first_addr", {16'd0, prev_wr_addr}, 32'h0000FFFF);
        check("t2_first_data", {24'd0, prev_wr_data}, 32'h00000011);
        check("t2_wrap_addr", {16'd0, last_wr_addr}, 32'h00000000);
        check("t2_wrap_data", {24'd0, last_wr_data}, 32'h00000022);

        // 3: set pointer, then read one byte with NA
        rf[16'h1234] = 8'h5A;
        m_mem[16'h1234] = 8'h5A;
        tx_q = '{8'h12, 8'h34};
        write_txn(8'h78, 1'b1);
        read_txn(1);
        check("t3_rd_addr", {16'd0, last_rd_addr}, 32'h00001234);
        check("t3_rd_byte", {24'd0, last_rd_byte}, 32'h0000005A);

        // 4: foreign ID is ignored, a following valid write works
        base = wr_seen;
        tx_q = '{8'hBE, 8'hEF, 8'hAA};
        write_txn(8'h42, 1'b1);
        check("t4_no_write", wr_seen - base, 32'd0);
        tx_q = '{8'h00, 8'h10, 8'h77};
        write_txn(8'h78, 1'b1);
        check("t4_wr_count", wr_seen - base, 32'd1);
        check("t4_wr_addr", {16'd0, last_wr_addr}, 32'h00000010);

        // 5: stop inside ADDR_L, then repeated start inside WDATA
        base = wr_seen;
        tx_q = '{8'hBE};
        write_txn(8'h78, 1'b0);
        for (int i = 0; i < 3; i++) xfer_bit(1'($urandom), s);
        bus_stop();
        check("t5_oe_after_stop", {31'd0, o_siod_oe}, 32'd0);
        check("t5_no_write", wr_seen - base, 32'd0);
        tx_q = '{8'h12, 8'h34, 8'h56};
        write_txn(8'h78, 1'b0);
        for (int i = 0; i < 2; i++) xfer_bit(1'($urandom), s);
        tx_q = '{8'hAB, 8'hCD, 8'h01};
        write_txn(8'h78, 1'b1);
        check("t5_wr_count", wr_seen - base, 32'd2);
        check("t5_restart_addr", {16'd0, last_wr_addr}, 32'h0000ABCD);

        // 6: reset asserted while the responder drives ACK
        dev = 8'h78;
        bus_start();
        for (int b = 7; b >= 0; b--) xfer_bit(dev[b], s);
        k = 0;
        while (!o_siod_oe && k < 20) begin
            @(posedge i_clk);
            k++;
        end
        check("t6_oe_in_ack", {31'd0, o_siod_oe}, 32'd1);
        #2 i_rst = 1'b1;
        #1;
        check("t6_oe_cleared", {31'd0, o_siod_oe}, 32'd0);
        check("t6_out_cleared", {31'd0, o_siod_out}, 32'd0);
        check("t6_busy_cleared", {31'd0, o_busy}, 32'd0);
        check("t6_rd_addr_cleared", {16'd0, o_rd_addr}, 32'd0);
        check("t6_wr_data_cleared", {24'd0, o_wr_data}, 32'd0);
        i_sioc = 1'b1;
        m_sda = 1'b1;
        exp_wr_q.delete();
        exp_rd_q.delete();
        m_ptr = 16'h0000;
        repeat (3) @(negedge i_clk);
        i_rst = 1'b0;
        #(4*Q);
        read_txn(1);
        check("t6_ptr_reset", {16'd0, last_rd_addr}, 32'h00000000);

        // Randomized mix of writes, reads, foreign IDs and write-then-read-back
        for (int t = 0; t < 14; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    tx_q.delete();
                    burst_addr = 16'($urandom);
                    tx_q.push_back(burst_addr[15:8]);
                    tx_q.push_back(burst_addr[7:0]);
                    for (int j = 0; j < int'($urandom_range(1, 3)); j++) tx_q.push_back(8'($urandom));
                    write_txn(8'h78, 1'b1);
                end
                1: read_txn(int'($urandom_range(1, 3)));
                2: begin
                    id = 8'($urandom);
                    if (id[7:1] == 7'h3C) id[7] = ~id[7];
                    tx_q.delete();
                    tx_q.push_back(8'($urandom));
                    tx_q.push_back(8'($urandom));
                    tx_q.push_back(8'($urandom));
                    write_txn(id, 1'b1);
                end
                default: begin
                    tx_q.delete();
                    tx_q.push_back(burst_addr[15:8]);
                    tx_q.push_back(burst_addr[7:0]);
                    write_txn(8'h78, 1'b1);
                    read_txn(int'($urandom_range(1, 2)));
                end
            endcase
        end

        check("final_wr_queue", exp_wr_q.size(), 32'd0);
        check("final_rd_queue", exp_rd_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
